crypt_seq_ctrl: RTL

// - Memory-to-memory sequencer around the Crypt XOR unit: encrypts/decrypts a block of LEN words in

---
 rtl/crypt_pkg.sv | 20 ++
 rtl/crypt_seq_ctrl_crypt.sv | 10 +
 rtl/crypt_seq_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared state codes, constants and key-rotate helper for crypt blocks
package crypt_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RD   = 2'd1;
   localparam state_t ST_WR   = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam int WORD_BYTES      = 4;
   localparam int DEFAULT_KEY_ROT = 1;

   // Rotate amount is taken mod 32 by the caller; 0 leaves the key fixed.
   function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
      if (n == 0) return v;
      return (v << n) | (v >> (32 - n));
   endfunction

endpackage

// File: rtl/crypt_seq_ctrl_crypt.sv
// rtl/crypt_seq_ctrl_crypt.sv - Crypt XOR unit: data_out = data_in ^ key
module crypt_seq_ctrl_crypt (
   input  logic [31:0] data_in,
   input  logic [31:0] key,
   output logic [31:0] data_out
);

   assign data_out = data_in ^ key;

endmodule

// File: rtl/crypt_seq_ctrl.sv
// rtl/crypt_seq_ctrl.sv - in-place block encrypt/decrypt sequencer driving a word memory port
module crypt_seq_ctrl
   import crypt_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 16,
   parameter int KEY_ROT = DEFAULT_KEY_ROT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [31:0]       key,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int ROT = KEY_ROT % 32;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       key_q;
   logic [31:0]       rdata_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic              err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         key_q   <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q <= base_addr;
                  key_q  <= key;
                  cnt_q  <= '0;
                  len_q  <= len;
                  err_q  <= 1'b0;
                  if (len == '0) begin
                     state <= ST_DONE;
                  end else if (base_addr[1:0] != 2'b00) begin
                     err_q <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  state   <= ST_WR;
               end
            end
            ST_WR: begin
               // abort is only looked at here so a word is never left half-processed
               if (mem_ack) begin
                  cnt_q  <= cnt_q + LEN_W'(1);
                  addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                  key_q  <= rotl32(key_q, ROT);
                  if ((cnt_q + LEN_W'(1) == len_q) || abort) state <= ST_DONE;
                  else                                        state <= ST_RD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Port outputs decode the registered state only, so mem_ack never reaches them combinationally.
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign err        = err_q;
   assign words_done = cnt_q;
   assign mem_req    = (state == ST_RD) || (state == ST_WR);
   assign mem_we     = (state == ST_WR);
   assign mem_addr   = addr_q;

   crypt_seq_ctrl_crypt u_crypt (
      .data_in  (rdata_q),
      .key      (key_q),
      .data_out (mem_wdata)
   );

endmodule
